// File: rtl/i2c_slave.sv
// I2C slave: 7-bit addressed receiver/transmitter driven from an asynchronous
// SCL/SDA pair, oversampled on sys_clk. Writes are presented on rx_data/rx_valid;
// reads fetch a byte from tx_data when tx_req strobes.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h73
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic       scl_m, scl_s, scl_d;
  logic       sda_m, sda_s, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] byte_in;
  logic       rw;
  logic       oe_r;
  logic       addr_hit;

  // Two-stage synchronisers plus one edge register per line; idle bus is high
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda_in;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  // Bus events and address decode
  always_comb begin
    scl_rise  = scl_s & ~scl_d;
    scl_fall  = ~scl_s & scl_d;
    start_det = scl_s & scl_d & sda_d & ~sda_s;
    stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    byte_in   = {shift[6:0], sda_s};
    // General call and the 10-bit prefix are never acknowledged
    addr_hit  = (byte_in[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00) &&
                (SLAVE_ADDR[6:2] != 5'b11110);
  end

  // Protocol FSM, shift register, strobes and SDA drive
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= 1'b0;
      oe_r     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        oe_r    <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ADDR;
        oe_r    <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_hit) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= sda_s;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          // First fall asserts the ACK, second fall ends the ACK bit.
          // Entering RD_DATA drives tx_data[7] immediately and keeps the
          // remaining bits pre-shifted, so shift[7] is always the next bit.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!oe_r) begin
                oe_r <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (rw) begin
                  state  <= RD_DATA;
                  tx_req <= 1'b1;
                  shift  <= {tx_data[6:0], 1'b0};
                  oe_r   <= ~tx_data[7];
                end else begin
                  state <= WR_DATA;
                  oe_r  <= 1'b0;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= byte_in;
                rx_valid <= 1'b1;
                state    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!oe_r) begin
                oe_r <= 1'b1;
              end else begin
                oe_r    <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_DATA;
              end
            end
          end
          // Bits are counted on rises; the counter wrapping to 0 marks the
          // fall after the eighth bit.
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                oe_r  <= 1'b0;
                state <= RD_ACK;
              end else begin
                oe_r  <= ~shift[7];
                shift <= {shift[6:0], 1'b0};
              end
            end
          end
          // A NACK leaves on the rise; any fall still here follows an ACK
          RD_ACK: begin
            if (scl_rise && sda_s) begin
              state <= IGNORE;
            end else if (scl_fall) begin
              state   <= RD_DATA;
              bit_cnt <= '0;
              tx_req  <= 1'b1;
              shift   <= {tx_data[6:0], 1'b0};
              oe_r    <= ~tx_data[7];
            end
          end
          default: begin
            oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Reset releases SDA combinationally, without waiting for a clock edge
  always_comb begin
    sda_oe = oe_r & ~sys_rst;
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on a wired-AND SDA line.
module tb_i2c_slave;

  localparam int T = 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  int total = 0;
  int bad = 0;
  int rxv_n = 0, txr_n = 0, oe_n = 0, busy_n = 0, both_n = 0;
  int rxv0, txr0, oe0, busy0;
  logic       a;
  logic [7:0] d;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(7'h73)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .scl     (scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse and activity counters
  always @(posedge sys_clk) begin
    if (rx_valid) rxv_n++;
    if (tx_req) txr_n++;
    if (sda_oe) oe_n++;
    if (busy) busy_n++;
    if (rx_valid && tx_req) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    rxv0 = rxv_n; txr0 = txr_n; oe0 = oe_n; busy0 = busy_n;
  endtask

  task automatic start_c();
    #T; m_sda = 1'b0; #T; scl = 1'b0; #T;
  endtask

  task automatic rstart_c();
    m_sda = 1'b1; #T; scl = 1'b1; #T; m_sda = 1'b0; #T; scl = 1'b0; #T;
  endtask

  task automatic stop_c();
    m_sda = 1'b0; #T; scl = 1'b1; #T; m_sda = 1'b1; #T;
  endtask

  task automatic clk_bit(input logic b, output logic seen);
    m_sda = b; #T; scl = 1'b1; #(T/2); seen = sda_bus; #(T/2); scl = 1'b0; #T;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_seen);
    logic s;
    for (int i = 0; i < 8; i++) clk_bit(b[7-i], s);
    clk_bit(1'b1, ack_seen);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] dv);
    logic s;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      dv[7-i] = s;
    end
    clk_bit(nack, s);
  endtask

  initial begin
    sys_rst = 1'b1; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    #23;
    chk("rst_oe", sda_oe, 0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_txr", tx_req, 0);
    chk("rst_busy", busy, 0);
    sys_rst = 1'b0;
    #77;

    // Write 0xA5 to our address
    snap();
    start_c();
    send_byte(8'hE6, a); chk("wr_addr_ack", a, 0);
    chk("wr_busy", busy, 1);
    send_byte(8'hA5, a); chk("wr_data_ack", a, 0);
    chk("wr_rxv_cnt", rxv_n - rxv0, 1);
    chk("wr_rx", rx_data, 8'hA5);
    chk("wr_txr_cnt", txr_n - txr0, 0);
    stop_c();
    chk("wr_busy_stop", busy, 0);

    // Foreign address: block must stay silent
    snap();
    start_c();
    send_byte(8'hA4, a); chk("na_addr_ack", a, 1);
    send_byte(8'h11, a); chk("na_data_ack", a, 1);
    stop_c();
    chk("na_oe_cnt", oe_n - oe0, 0);
    chk("na_rxv_cnt", rxv_n - rxv0, 0);
    chk("na_busy_cnt", busy_n - busy0, 0);

    // Read 0x3C with master NACK
    snap();
    tx_data = 8'h3C;
    start_c();
    send_byte(8'hE7, a); chk("rd_addr_ack", a, 0);
    read_byte(1'b1, d);
    chk("rd_data", d, 8'h3C);
    chk("rd_txr_cnt", txr_n - txr0, 1);
    chk("rd_busy", busy, 1);
    snap();
    send_byte(8'hFF, a); chk("ign_ack", a, 1);
    chk("ign_oe_cnt", oe_n - oe0, 0);
    chk("ign_txr_cnt", txr_n - txr0, 0);
    stop_c();
    chk("rd_busy_stop", busy, 0);

    // Partial write cut by repeated START, then a read
    snap();
    start_c();
    send_byte(8'hE6, a); chk("rs_addr_ack", a, 0);
    clk_bit(1'b1, a); clk_bit(1'b0, a); clk_bit(1'b1, a); clk_bit(1'b0, a);
    rstart_c();
    tx_data = 8'h96;
    send_byte(8'hE7, a); chk("rs_addr2_ack", a, 0);
    chk("rs_txr_cnt", txr_n - txr0, 1);
    chk("rs_rxv_cnt", rxv_n - rxv0, 0);
    read_byte(1'b1, d);
    chk("rs_data", d, 8'h96);
    stop_c();
    chk("rs_busy_stop", busy, 0);

    // Reset during the address ACK slot
    start_c();
    for (int i = 0; i < 8; i++) begin
      d = 8'hE6;
      clk_bit(d[7-i], a);
    end
    m_sda = 1'b1; #T; scl = 1'b1; #(T/2);
    chk("ack_before_rst", sda_oe, 1);
    sys_rst = 1'b1; #1;
    chk("oe_in_rst", sda_oe, 0);
    chk("busy_in_rst", busy, 0);
    #30; sys_rst = 1'b0; #19;
    scl = 1'b0; #T;
    stop_c();
    start_c();
    send_byte(8'hE6, a); chk("pr_addr_ack", a, 0);
    send_byte(8'h5A, a); chk("pr_data_ack", a, 0);
    chk("pr_rx", rx_data, 8'h5A);
    stop_c();

    // Five data bits then STOP: byte dropped, block back to idle
    snap();
    start_c();
    send_byte(8'hE6, a); chk("pb_addr_ack", a, 0);
    clk_bit(1'b1, a); clk_bit(1'b0, a); clk_bit(1'b1, a); clk_bit(1'b1, a); clk_bit(1'b0, a);
    stop_c();
    chk("pb_rxv_cnt", rxv_n - rxv0, 0);
    chk("pb_rx", rx_data, 8'h5A);
    chk("pb_busy", busy, 0);
    scl = 1'b0; #T;
    send_byte(8'hE6, a); chk("idle_no_ack", a, 1);
    stop_c();

    chk("strobe_overlap", both_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
